// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared types and helpers for the programmable serial sequence detector.
//   seq_state_t : detector state (IDLE = unconfigured, RUN = detecting)
//   MASK_W      : width of the mask produced by len_mask (upper bound on MAX_LEN)
//   len_mask()  : low-order mask with the bottom 'len' bits set
// -----------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // The package cannot see the top's MAX_LEN, so the mask is built at a
    // fixed upper width; callers zero-extend their operand to MASK_W bits.
    localparam int MASK_W = 64;

    function automatic logic [MASK_W-1:0] len_mask(input int len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detector_prog_cnt.sv
// -----------------------------------------------------------------------------
// seq_match_cnt
// Saturating up-counter with a synchronous clear that beats a same-cycle
// increment.
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   i_clr  : clear to zero (priority over i_inc)
//   i_inc  : increment by one, holding at all-ones
//   o_cnt  : registered count
// -----------------------------------------------------------------------------
module seq_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count register: reset, clear, saturating increment, else hold.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_prog.sv
// -----------------------------------------------------------------------------
// seq_detector_prog
// Runtime-programmable serial bit-sequence detector with overlap or
// non-overlap matching and a saturating match counter.
//
// Optional build macro: SEQ_DET_MASK_EN adds cfg_mask, per-position
// don't-care bits latched with the pattern.
//
// Ports:
//   clk, resetn   : clock (rising edge), synchronous active-low reset
//   cfg_load      : one-cycle strobe capturing cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern   : pattern; bit[len-1] is received first, bit[0] last
//   cfg_len       : pattern length, accepted range 1..MAX_LEN
//   cfg_overlap   : 1 = overlapping matches, 0 = non-overlapping
//   cfg_mask      : (SEQ_DET_MASK_EN only) 1 = position is don't-care
//   cfg_err       : one-cycle pulse after a rejected cfg_load
//   armed         : high while in RUN
//   in_valid, in  : qualified serial data bit
//   out           : one-cycle match pulse, one cycle after the completing beat
//   cnt_clr       : synchronous clear of match_cnt
//   match_cnt     : saturating match count
// MAX_LEN must lie in 2..64.
// -----------------------------------------------------------------------------
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
`ifdef SEQ_DET_MASK_EN
    input  logic [MAX_LEN-1:0] cfg_mask,
`endif
    output logic               cfg_err,
    output logic               armed,
    input  logic               in_valid,
    input  logic               in,
    output logic               out,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   match_cnt
);

    seq_state_t         r_state;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_out;
    logic               r_cfg_err;
    logic               r_armed;

    logic               w_cfg_ok;
    logic               w_beat;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_care;
    logic [MAX_LEN-1:0] w_diff;
    logic               w_hit;

`ifdef SEQ_DET_MASK_EN
    logic [MAX_LEN-1:0] r_mask;
    assign w_care = ~r_mask;
`else
    assign w_care = {MAX_LEN{1'b1}};
`endif

    assign w_cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    // A load in the same cycle drops the data beat entirely.
    assign w_beat = (r_state == RUN) && in_valid && !cfg_load;

    // Shifting the whole register (rather than slicing) keeps every history
    // bit in the expression; the MSB falls off as the new bit enters bit 0.
    assign w_hist_next = (r_hist << 1'b1) | MAX_LEN'(in);
    assign w_fill_next = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : (r_fill + LEN_W'(1));

    // Differences on cared-for positions; the length mask drops bits >= len.
    assign w_diff = (w_hist_next ^ r_pattern) & w_care;
    assign w_hit  = w_beat && (w_fill_next >= r_len) &&
                    ((MASK_W'(w_diff) & len_mask(int'(r_len))) == '0);

    // Control FSM, configuration, history/fill and registered pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_out     <= 1'b0;
            r_cfg_err <= 1'b0;
            r_armed   <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            r_mask    <= '0;
`endif
        end else begin
            r_out     <= w_hit;
            r_cfg_err <= cfg_load && !w_cfg_ok;
            if (cfg_load && w_cfg_ok) begin
                r_state   <= RUN;
                r_armed   <= 1'b1;
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_hist    <= '0;
                r_fill    <= '0;
`ifdef SEQ_DET_MASK_EN
                r_mask    <= cfg_mask;
`endif
            end else if (w_beat) begin
                r_hist <= w_hist_next;
                // Non-overlap restarts the fill so the next match needs len fresh beats.
                if (w_hit && !r_overlap) begin
                    r_fill <= '0;
                end else begin
                    r_fill <= w_fill_next;
                end
            end else begin
                r_state <= r_state;
                r_armed <= r_armed;
            end
        end
    end

    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (cnt_clr),
        .i_inc  (w_hit),
        .o_cnt  (match_cnt)
    );

    assign out     = r_out;
    assign cfg_err = r_cfg_err;
    assign armed   = r_armed;

endmodule

// File: tb/tb_seq_detector_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_prog
// Directed stimulus drives the detector on falling edges and pushes the hand
// computed pulses it expects (kind, cycle, match_cnt) into a queue; a monitor
// pops and compares whenever out or cfg_err is seen.
// -----------------------------------------------------------------------------
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic [MAX_LEN-1:0] cfg_mask = '0;
    logic               cfg_err;
    logic               armed;
    logic               in_valid = 1'b0;
    logic               in = 1'b0;
    logic               out;
    logic               cnt_clr = 1'b0;
    logic [CNT_W-1:0]   match_cnt;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        bit is_err;
        int cyc;
        int cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    seq_detector_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask    (cfg_mask),
`endif
        .cfg_err     (cfg_err),
        .armed       (armed),
        .in_valid    (in_valid),
        .in          (in),
        .out         (out),
        .cnt_clr     (cnt_clr),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every observed pulse must match the head of the queue.
    always @(negedge clk) begin
        if (out === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("out_kind_is_err", 0, int'(mon_e.is_err));
                chk("out_cycle", cyc, mon_e.cyc);
                chk("out_match_cnt", int'(match_cnt), mon_e.cnt);
            end
        end
        if (cfg_err === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_cfg_err: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("err_kind_is_err", 1, int'(mon_e.is_err));
                chk("err_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // One clock of stimulus; eo/ee announce an out/cfg_err pulse next cycle.
    task automatic step(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                        input logic ovl, input logic [7:0] msk, input logic v,
                        input logic b, input logic clr, input bit eo, input bit ee,
                        input int ec);
        exp_t e;
        @(negedge clk);
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_mask    = msk;
        in_valid    = v;
        in          = b;
        cnt_clr     = clr;
        if (eo) begin
            e.is_err = 1'b0; e.cyc = cyc + 1; e.cnt = ec;
            q.push_back(e);
        end
        if (ee) begin
            e.is_err = 1'b1; e.cyc = cyc + 1; e.cnt = 0;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic bubble();
        step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic clr();
        step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic beat(input logic b, input bit eo, input int ec);
        step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b1, b, 1'b0, eo, 1'b0, ec);
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                       input logic [7:0] msk, input bit ee);
        step(1'b1, pat, len, ovl, msk, 1'b0, 1'b0, 1'b0, 1'b0, ee, 0);
    endtask

    task automatic rst_cycle(input bit check);
        @(negedge clk);
        resetn   = 1'b0;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        @(negedge clk);
        if (check) begin
            chk("rst_out", int'(out), 0);
            chk("rst_cfg_err", int'(cfg_err), 0);
            chk("rst_armed", int'(armed), 0);
            chk("rst_match_cnt", int'(match_cnt), 0);
        end
        resetn = 1'b1;
    endtask

    initial begin
        rst_cycle(1'b1);

        // Overlap 1001: 1,0,0,1,0,0,1 -> hits on beats 4 and 7.
        cfg(8'b1001, 4'd4, 1'b1, 8'h00, 1'b0);
        idle();
        chk("armed_after_load", int'(armed), 1);
        beat(1'b1, 1'b0, 0); beat(1'b0, 1'b0, 0); beat(1'b0, 1'b0, 0);
        beat(1'b1, 1'b1, 1);
        beat(1'b0, 1'b0, 0); beat(1'b0, 1'b0, 0);
        beat(1'b1, 1'b1, 2);
        idle();
        chk("cnt_overlap", int'(match_cnt), 2);

        // Non-overlap: same stream -> only the beat-4 hit.
        clr();
        idle();
        chk("cnt_after_clr", int'(match_cnt), 0);
        cfg(8'b1001, 4'd4, 1'b0, 8'h00, 1'b0);
        beat(1'b1, 1'b0, 0); beat(1'b0, 1'b0, 0); beat(1'b0, 1'b0, 0);
        beat(1'b1, 1'b1, 1);
        beat(1'b0, 1'b0, 0); beat(1'b0, 1'b0, 0); beat(1'b1, 1'b0, 0);
        idle();
        chk("cnt_nonoverlap", int'(match_cnt), 1);
        chk("armed_after_reload", int'(armed), 1);

        // 1101 with invalid bubbles (in=1 while invalid must not shift in).
        clr();
        cfg(8'b1101, 4'd4, 1'b1, 8'h00, 1'b0);
        beat(1'b1, 1'b0, 0); bubble();
        beat(1'b1, 1'b0, 0); bubble(); bubble();
        beat(1'b0, 1'b0, 0); bubble();
        beat(1'b1, 1'b1, 1);
        idle();

        // cfg_load with a valid beat: beat dropped, history restarted.
        clr();
        cfg(8'b1001, 4'd4, 1'b1, 8'h00, 1'b0);
        beat(1'b1, 1'b0, 0); beat(1'b0, 1'b0, 0); beat(1'b0, 1'b0, 0);
        step(1'b1, 8'b1001, 4'd4, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        beat(1'b1, 1'b0, 0); beat(1'b0, 1'b0, 0); beat(1'b0, 1'b0, 0);
        beat(1'b1, 1'b1, 1);
        idle();

        // Reset after 3 of 4 bits, reload, send only the 4th bit.
        cfg(8'b1001, 4'd4, 1'b1, 8'h00, 1'b0);
        beat(1'b1, 1'b0, 0); beat(1'b0, 1'b0, 0); beat(1'b0, 1'b0, 0);
        rst_cycle(1'b1);
        cfg(8'b1001, 4'd4, 1'b1, 8'h00, 1'b0);
        beat(1'b1, 1'b0, 0);
        idle();
        chk("armed_after_reset_reload", int'(armed), 1);

        // Rejected loads from IDLE: len 0 and len MAX_LEN+1.
        rst_cycle(1'b0);
        cfg(8'hFF, 4'd0, 1'b1, 8'h00, 1'b1);
        cfg(8'hFF, 4'd9, 1'b1, 8'h00, 1'b1);
        idle();
        chk("armed_after_reject", int'(armed), 0);
        for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 0);
        idle();
        chk("cnt_idle_stream", int'(match_cnt), 0);

        // len 1: eight hits saturate a 2-bit counter at 3.
        cfg(8'b0000_0001, 4'd1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) beat(1'b1, 1'b1, (i < 3) ? i + 1 : 3);
        idle();
        chk("cnt_saturated", int'(match_cnt), 3);
        // Clear with a matching beat: pulse still emitted, count reads 0.
        step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        beat(1'b0, 1'b0, 0);
        idle();
        chk("cnt_clr_priority", int'(match_cnt), 0);
        // Reject while running leaves len-1 pattern in place.
        cfg(8'h00, 4'd0, 1'b0, 8'h00, 1'b1);
        beat(1'b1, 1'b1, 1);
        idle();
        chk("armed_after_run_reject", int'(armed), 1);

`ifdef SEQ_DET_MASK_EN
        // Position 2 masked: 1101 and 1001 both match 1001.
        clr();
        cfg(8'b1001, 4'd4, 1'b1, 8'b0100, 1'b0);
        beat(1'b1, 1'b0, 0); beat(1'b1, 1'b0, 0); beat(1'b0, 1'b0, 0);
        beat(1'b1, 1'b1, 1);
        cfg(8'b1001, 4'd4, 1'b1, 8'b0100, 1'b0);
        beat(1'b1, 1'b0, 0); beat(1'b0, 1'b0, 0); beat(1'b0, 1'b0, 0);
        beat(1'b1, 1'b1, 2);
        idle();
`endif

        idle();
        idle();
        chk("pending_expected_pulses", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
